// File: rtl/flex_counter_ctrl.sv
// rtl/flex_counter_ctrl.sv - period/repeat sequencer driving flex_counter; optional prescaler via FLEX_COUNTER_CTRL_PRESCALE_EN
`ifndef NUM_CNT_BITS
`define NUM_CNT_BITS 4
`endif

module flex_counter_ctrl #(
    parameter int NUM_CNT_BITS = `NUM_CNT_BITS,
    parameter int REPEAT_BITS  = 8,
    parameter int PRESCALE_DIV = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [NUM_CNT_BITS-1:0] cmd_period,
    input  logic [REPEAT_BITS-1:0]  cmd_repeat,
    input  logic                    stop,
    input  logic                    event_in,
    output logic                    clear,
    output logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CNT_BITS-1:0] count_out,
    input  logic                    rollover_flag,
    output logic                    busy,
    output logic                    period_tick,
    output logic                    done,
    output logic [REPEAT_BITS-1:0]  periods_left
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [NUM_CNT_BITS-1:0] rv_q, rv_d;
    logic [REPEAT_BITS-1:0]  pl_q, pl_d;
    logic                    en_q, en_d;
    logic                    tick;
    logic                    running;
    logic                    unused_ok;

    // count_out is status only; fold it into a sink so it stays on the port
    assign unused_ok = ^count_out;

    assign running = (state_q == S_ARM) || (state_q == S_RUN);

    // A flag counts only when the previous cycle actually stepped the counter,
    // so a counter sitting on its rollover value is not counted twice.
    assign tick = (state_q == S_RUN) && rollover_flag && en_q;

`ifdef FLEX_COUNTER_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          presc_last;

    assign presc_last = (presc_q == PW'(PRESCALE_DIV - 1));

    // Event prescaler: restarts on every arm, wraps after PRESCALE_DIV events
    always_comb begin
        presc_d = presc_q;
        if (state_q == S_ARM) begin
            presc_d = '0;
        end else if ((state_q == S_RUN) && event_in) begin
            presc_d = presc_last ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign count_enable = !RST && (state_q == S_RUN) && event_in && presc_last;
`else
    localparam int unused_presc_div = PRESCALE_DIV;

    assign count_enable = !RST && (state_q == S_RUN) && event_in;
`endif

    assign en_d         = count_enable;
    assign cmd_ready    = !RST && (state_q == S_IDLE);
    assign busy         = !RST && running;
    assign clear        = RST || (state_q == S_ARM) || (state_q == S_DONE) || (running && stop);
    assign period_tick  = !RST && tick;
    assign done         = !RST && (state_q == S_DONE);
    assign rollover_val = rv_q;
    assign periods_left = pl_q;

    // Sequencer next-state: accept, arm one cycle, run until repeat exhausted or stop
    always_comb begin
        state_d = state_q;
        rv_d    = rv_q;
        pl_d    = pl_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rv_d    = (cmd_period == '0) ? NUM_CNT_BITS'(1) : cmd_period;
                    pl_d    = cmd_repeat;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (stop) begin
                    pl_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    pl_d    = '0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (pl_q == REPEAT_BITS'(1)) begin
                        pl_d    = '0;
                        state_d = S_DONE;
                    end else if (pl_q != '0) begin
                        pl_d = pl_q - REPEAT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            rv_q    <= '0;
            pl_q    <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= rv_d;
            pl_q    <= pl_d;
            en_q    <= en_d;
        end
    end

endmodule
